// File: rtl/score_display_ctrl.sv
// score_display_ctrl: score-to-BCD sequencer and pixel addressing for the digit-glyph ROM.
// Converts the binary score with a serial double-dabble, commits digits only outside
// the score rows, and drives the ROM select/count with a two-stage pixel pipeline.
module score_display_ctrl #(
    parameter int SCORE_W = 10,
    parameter int DIGITS  = 3,
    parameter int X0      = 560,
    parameter int Y0      = 10
) (
    input  logic               clock_25,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_load,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    output logic [4:0]         selected_number,
    output logic [7:0]         count,
    output logic               in_region,
    output logic               busy
);

    localparam int BCD_W    = 4 * DIGITS;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BITCNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int MAX_VAL  = 10**DIGITS - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t               r_state;
    logic [SCORE_W-1:0]   r_bin;
    logic [BCD_W-1:0]     r_bcd;
    logic [BITCNT_W-1:0]  r_bitCnt;
    logic                 r_sat;
    logic                 r_pending;
    logic [SCORE_W-1:0]   r_pendScore;
    logic                 r_busy;
    logic [3:0]           r_digit [DIGITS];

    logic                 r_hit;
    logic                 r_show;
    logic [3:0]           r_row;
    logic [3:0]           r_col;
    logic [4:0]           r_sel;
    logic [7:0]           r_count;
    logic                 r_inRegion;

    logic                 w_yInField;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_idx;
    logic [3:0]           w_col;
    logic [3:0]           w_row;
    logic [DIGITS-1:0]    w_blank;
    logic                 w_zeroRun;
    logic [7:0]           w_linear;

    // Scores that cannot be shown in DIGITS decimal places display as all nines.
    function automatic logic isSat(input logic [SCORE_W-1:0] v);
        return 32'(v) > 32'(MAX_VAL);
    endfunction

    // Double-dabble correction: every BCD nibble of 5 or more gets 3 added.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] res;
        res = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    assign w_yInField = (32'(pixel_y) >= 32'(Y0)) && (32'(pixel_y) <= 32'(Y0 + 9));

    // Conversion FSM: latch, shift SCORE_W times, then commit outside the score rows.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_bitCnt    <= '0;
            r_sat       <= 1'b0;
            r_pending   <= 1'b0;
            r_pendScore <= '0;
            r_busy      <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_digit[i] <= 4'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (score_load) begin
                        r_bin    <= score;
                        r_bcd    <= '0;
                        r_bitCnt <= '0;
                        r_sat    <= isSat(score);
                        r_state  <= SHIFT;
                        r_busy   <= 1'b1;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {add3(r_bcd), r_bin} << 1;
                    r_bitCnt       <= r_bitCnt + 1'b1;
                    if (r_bitCnt == BITCNT_W'(SCORE_W - 1)) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (!w_yInField) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            r_digit[i] <= r_sat ? 4'd9 : r_bcd[BCD_W-4-4*i +: 4];
                        end
                        if (r_pending) begin
                            r_bin    <= r_pendScore;
                            r_bcd    <= '0;
                            r_bitCnt <= '0;
                            r_sat    <= isSat(r_pendScore);
                            r_state  <= SHIFT;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A load while busy is parked; a newer load replaces it, and a load on the
            // cycle the parked value is consumed stays parked for the next round.
            if (score_load && (r_state != IDLE)) begin
                r_pending   <= 1'b1;
                r_pendScore <= score;
            end else if ((r_state == COMMIT) && !w_yInField && r_pending) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Region decode: digit index by compare chain, column/row offsets within the glyph.
    always_comb begin
        w_hit = w_yInField &&
                (32'(pixel_x) >= 32'(X0)) &&
                (32'(pixel_x) <  32'(X0 + 10*DIGITS));
        w_idx = '0;
        w_col = 4'd0;
        w_row = 4'(32'(pixel_y) - 32'(Y0));
        for (int i = 0; i < DIGITS; i++) begin
            if (32'(pixel_x) >= 32'(X0 + 10*i)) begin
                w_idx = IDX_W'(i);
                w_col = 4'(32'(pixel_x) - 32'(X0 + 10*i));
            end
        end
    end

    // Leading-zero mask: a digit blanks while it and everything left of it is zero,
    // except the rightmost digit, which always shows.
    always_comb begin
        w_zeroRun = 1'b1;
        w_blank   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_zeroRun  = w_zeroRun && (r_digit[i] == 4'd0);
            w_blank[i] = w_zeroRun && (i != DIGITS - 1);
        end
    end

    // First pixel stage: glyph select to the ROM plus the offsets it will need next cycle.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_sel  <= 5'd0;
            r_hit  <= 1'b0;
            r_show <= 1'b0;
            r_row  <= 4'd0;
            r_col  <= 4'd0;
        end else begin
            r_sel  <= w_hit ? {1'b0, r_digit[w_idx]} : 5'd0;
            r_hit  <= w_hit;
            r_show <= w_hit && !w_blank[w_idx];
            r_row  <= w_row;
            r_col  <= w_col;
        end
    end

    assign w_linear = 8'(r_row) * 8'd10 + 8'(r_col);

    // Second pixel stage: bit offset and visibility line up with the ROM's registered select.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_count    <= 8'd0;
            r_inRegion <= 1'b0;
        end else begin
            r_count    <= r_hit ? (w_linear << 1) : 8'd0;
            r_inRegion <= r_show;
        end
    end

    assign selected_number = r_sel;
    assign count           = r_count;
    assign in_region       = r_inRegion;
    assign busy            = r_busy;

endmodule
